// File: rtl/udp_tx_arbiter.sv
// Two-source round-robin arbiter feeding one UDP header + payload stream; a frame owns the output from header to tlast.
// Optional payload-stall watchdog enabled by defining UDP_TX_ARB_WDOG_EN (limit set by WDOG_CYCLES).
module udp_tx_arbiter #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_udp_hdr_valid,
  output logic        s0_udp_hdr_ready,
  input  logic [31:0] s0_udp_ip_dest_ip,
  input  logic [15:0] s0_udp_source_port,
  input  logic [15:0] s0_udp_dest_port,
  input  logic [15:0] s0_udp_length,
  input  logic [7:0]  s0_udp_payload_axis_tdata,
  input  logic        s0_udp_payload_axis_tvalid,
  input  logic        s0_udp_payload_axis_tlast,
  input  logic        s0_udp_payload_axis_tuser,
  output logic        s0_udp_payload_axis_tready,
  input  logic        s1_udp_hdr_valid,
  output logic        s1_udp_hdr_ready,
  input  logic [31:0] s1_udp_ip_dest_ip,
  input  logic [15:0] s1_udp_source_port,
  input  logic [15:0] s1_udp_dest_port,
  input  logic [15:0] s1_udp_length,
  input  logic [7:0]  s1_udp_payload_axis_tdata,
  input  logic        s1_udp_payload_axis_tvalid,
  input  logic        s1_udp_payload_axis_tlast,
  input  logic        s1_udp_payload_axis_tuser,
  output logic        s1_udp_payload_axis_tready,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  input  logic        m_udp_payload_axis_tready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        wdog_abort,
  output logic [1:0]  dbg_state
);

  // Handshake rule: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2, DRAIN = 2'd3} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic       sel_hdr_valid;
  logic [7:0] sel_tdata;
  logic       sel_tvalid, sel_tlast, sel_tuser;
  logic       wdog_hit;

  // Everything is steered by the registered grant; with no owner all fields read as zero.
  always_comb begin
    sel_hdr_valid     = 1'b0;
    m_udp_ip_dest_ip  = '0;
    m_udp_source_port = '0;
    m_udp_dest_port   = '0;
    m_udp_length      = '0;
    sel_tdata         = '0;
    sel_tvalid        = 1'b0;
    sel_tlast         = 1'b0;
    sel_tuser         = 1'b0;
    if (grant_q[0]) begin
      sel_hdr_valid     = s0_udp_hdr_valid;
      m_udp_ip_dest_ip  = s0_udp_ip_dest_ip;
      m_udp_source_port = s0_udp_source_port;
      m_udp_dest_port   = s0_udp_dest_port;
      m_udp_length      = s0_udp_length;
      sel_tdata         = s0_udp_payload_axis_tdata;
      sel_tvalid        = s0_udp_payload_axis_tvalid;
      sel_tlast         = s0_udp_payload_axis_tlast;
      sel_tuser         = s0_udp_payload_axis_tuser;
    end else if (grant_q[1]) begin
      sel_hdr_valid     = s1_udp_hdr_valid;
      m_udp_ip_dest_ip  = s1_udp_ip_dest_ip;
      m_udp_source_port = s1_udp_source_port;
      m_udp_dest_port   = s1_udp_dest_port;
      m_udp_length      = s1_udp_length;
      sel_tdata         = s1_udp_payload_axis_tdata;
      sel_tvalid        = s1_udp_payload_axis_tvalid;
      sel_tlast         = s1_udp_payload_axis_tlast;
      sel_tuser         = s1_udp_payload_axis_tuser;
    end
  end

`ifdef UDP_TX_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_q, wdog_d;

  assign wdog_hit = (state_q == PAYLOAD) && (wdog_q == CW'(WDOG_CYCLES));

  // Counts stalled payload cycles; holds at the limit until the forced beat leaves PAYLOAD.
  always_comb begin
    wdog_d = '0;
    if (state_q == PAYLOAD) begin
      if (wdog_hit) wdog_d = wdog_q;
      else if (!(sel_tvalid && m_udp_payload_axis_tready)) wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  // No watchdog: the stall limit can never be reached.
  assign wdog_hit = (WDOG_CYCLES < 0);
`endif

  always_comb begin
    state_d                    = state_q;
    grant_d                    = grant_q;
    last_d                     = last_q;
    m_udp_hdr_valid            = 1'b0;
    s0_udp_hdr_ready           = 1'b0;
    s1_udp_hdr_ready           = 1'b0;
    m_udp_payload_axis_tdata   = '0;
    m_udp_payload_axis_tvalid  = 1'b0;
    m_udp_payload_axis_tlast   = 1'b0;
    m_udp_payload_axis_tuser   = 1'b0;
    s0_udp_payload_axis_tready = 1'b0;
    s1_udp_payload_axis_tready = 1'b0;
    wdog_abort                 = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_udp_hdr_valid || s1_udp_hdr_valid) begin
          if (s0_udp_hdr_valid && s1_udp_hdr_valid) grant_d = last_q ? 2'b01 : 2'b10;
          else                                      grant_d = s0_udp_hdr_valid ? 2'b01 : 2'b10;
          state_d = HDR;
        end
      end
      HDR: begin
        m_udp_hdr_valid  = sel_hdr_valid;
        s0_udp_hdr_ready = grant_q[0] & m_udp_hdr_ready;
        s1_udp_hdr_ready = grant_q[1] & m_udp_hdr_ready;
        if (sel_hdr_valid && m_udp_hdr_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (wdog_hit) begin
          // Forced terminating beat: tlast + error flag, no data.
          m_udp_payload_axis_tvalid = 1'b1;
          m_udp_payload_axis_tlast  = 1'b1;
          m_udp_payload_axis_tuser  = 1'b1;
          if (m_udp_payload_axis_tready) begin
            wdog_abort = 1'b1;
            state_d    = DRAIN;
          end
        end else begin
          m_udp_payload_axis_tdata   = sel_tdata;
          m_udp_payload_axis_tvalid  = sel_tvalid;
          m_udp_payload_axis_tlast   = sel_tlast;
          m_udp_payload_axis_tuser   = sel_tuser;
          s0_udp_payload_axis_tready = grant_q[0] & m_udp_payload_axis_tready;
          s1_udp_payload_axis_tready = grant_q[1] & m_udp_payload_axis_tready;
          if (sel_tvalid && m_udp_payload_axis_tready && sel_tlast) begin
            state_d = IDLE;
            grant_d = 2'b00;
            last_d  = grant_q[1];
          end
        end
      end
      DRAIN: begin
        s0_udp_payload_axis_tready = grant_q[0];
        s1_udp_payload_axis_tready = grant_q[1];
        if (sel_tvalid && sel_tlast) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: random frames from two source drivers, a round-robin reference model and a beat scoreboard.
// Define UDP_TX_ARB_WDOG_EN to also exercise the stall watchdog with an 8-cycle limit.
module tb_udp_tx_arbiter;
`ifdef UDP_TX_ARB_WDOG_EN
  localparam int WDOG = 8;
`else
  localparam int WDOG = 1024;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        hv[2], hr[2], tv[2], tl[2], tu[2], tr[2];
  logic [31:0] dip[2];
  logic [15:0] sp[2], dp[2], ln[2];
  logic [7:0]  td[2];
  logic        m_hdr_valid, m_hdr_ready, m_tvalid, m_tlast, m_tuser, m_tready;
  logic [31:0] m_ip;
  logic [15:0] m_sp, m_dp, m_len;
  logic [7:0]  m_tdata;
  logic [1:0]  grant, dbg_state;
  logic        busy, wdog_abort;

  udp_tx_arbiter #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_udp_hdr_valid(hv[0]), .s0_udp_hdr_ready(hr[0]), .s0_udp_ip_dest_ip(dip[0]),
    .s0_udp_source_port(sp[0]), .s0_udp_dest_port(dp[0]), .s0_udp_length(ln[0]),
    .s0_udp_payload_axis_tdata(td[0]), .s0_udp_payload_axis_tvalid(tv[0]),
    .s0_udp_payload_axis_tlast(tl[0]), .s0_udp_payload_axis_tuser(tu[0]),
    .s0_udp_payload_axis_tready(tr[0]),
    .s1_udp_hdr_valid(hv[1]), .s1_udp_hdr_ready(hr[1]), .s1_udp_ip_dest_ip(dip[1]),
    .s1_udp_source_port(sp[1]), .s1_udp_dest_port(dp[1]), .s1_udp_length(ln[1]),
    .s1_udp_payload_axis_tdata(td[1]), .s1_udp_payload_axis_tvalid(tv[1]),
    .s1_udp_payload_axis_tlast(tl[1]), .s1_udp_payload_axis_tuser(tu[1]),
    .s1_udp_payload_axis_tready(tr[1]),
    .m_udp_hdr_valid(m_hdr_valid), .m_udp_hdr_ready(m_hdr_ready),
    .m_udp_ip_dest_ip(m_ip), .m_udp_source_port(m_sp), .m_udp_dest_port(m_dp),
    .m_udp_length(m_len), .m_udp_payload_axis_tdata(m_tdata),
    .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tlast(m_tlast),
    .m_udp_payload_axis_tuser(m_tuser), .m_udp_payload_axis_tready(m_tready),
    .grant(grant), .busy(busy), .wdog_abort(wdog_abort), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0: sink always ready, 1: payload ready toggles, 2: random readiness
  int last_m = 1;  // model: last-served source
  int cur    = 0;  // model: source owning the frame in flight

  logic [79:0] exp_hdr0[$], exp_hdr1[$];
  logic [9:0]  exp_beat0[$], exp_beat1[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int s);
    return (s == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk_idle(input string name);
    chk(name, {m_hdr_valid, m_tvalid, grant, busy, wdog_abort, hr[0], hr[1], tr[0], tr[1],
               m_ip, m_sp, m_dp, m_len, m_tdata, m_tlast, m_tuser}, '0);
  endtask

  task automatic chk_drained(input string name);
    chk(name, exp_hdr0.size() + exp_hdr1.size() + exp_beat0.size() + exp_beat1.size(), 0);
  endtask

  // Sink readiness
  initial begin
    m_hdr_ready = 1'b1;
    m_tready    = 1'b1;
    forever begin
      @(negedge clk);
      case (mode)
        0: begin m_hdr_ready = 1'b1; m_tready = 1'b1; end
        1: begin m_hdr_ready = 1'b1; m_tready = ~m_tready; end
        default: begin
          m_hdr_ready = 1'($urandom_range(0, 1));
          m_tready    = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // Source driver: pushes expectations, then sends header and beats; requests the next frame right after tlast.
  task automatic run_src(input int n, input int nframes, input int fixed_len, input logic [15:0] fixed_dport,
                         input int gap_pct, input int abort_at, input int stall_at, input int stall_cyc,
                         input bit wdog_expect);
    logic [7:0] bd[64];
    logic       bu[64];
    logic [79:0] h;
    int len, t;
    for (int f = 0; f < nframes; f++) begin
      len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 8));
      h = {32'($urandom), 16'($urandom_range(0, 65535)),
           (fixed_dport != 0) ? fixed_dport : 16'($urandom_range(0, 65535)), 16'(len + 8)};
      if (n == 0) exp_hdr0.push_back(h); else exp_hdr1.push_back(h);
      for (int i = 0; i < len; i++) begin
        bd[i] = 8'($urandom_range(0, 255));
        bu[i] = 1'($urandom_range(0, 1));
        if (!(wdog_expect && i >= stall_at)) begin
          if (n == 0) exp_beat0.push_back({bu[i], i == len - 1, bd[i]});
          else        exp_beat1.push_back({bu[i], i == len - 1, bd[i]});
        end
      end
      if (wdog_expect) begin
        if (n == 0) exp_beat0.push_back({1'b1, 1'b1, 8'h00});
        else        exp_beat1.push_back({1'b1, 1'b1, 8'h00});
      end
      @(negedge clk);
      tv[n] = 1'b0;
      hv[n] = 1'b1;
      {dip[n], sp[n], dp[n], ln[n]} = h;
      #1;
      t = 0;
      while (!hr[n] && t < 1000) begin @(negedge clk); #1; t++; end
      if (t >= 1000) begin
        checks++; errors++;
        $display("FAIL hdr_timeout src=%0d act=no_ready exp=ready", n);
        return;
      end
      @(posedge clk);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        hv[n] = 1'b0;
        if (i == stall_at) begin
          tv[n] = 1'b0;
          repeat (stall_cyc) @(negedge clk);
        end
        while ($urandom_range(0, 99) < gap_pct) begin tv[n] = 1'b0; @(negedge clk); end
        tv[n] = 1'b1;
        td[n] = bd[i];
        tl[n] = (i == len - 1);
        tu[n] = bu[i];
        if (i == abort_at) begin
          rst_n = 1'b0;
          return;
        end
        #1;
        t = 0;
        while (!tr[n] && t < 1000) begin @(negedge clk); #1; t++; end
        if (t >= 1000) begin
          checks++; errors++;
          $display("FAIL beat_timeout src=%0d act=no_ready exp=ready", n);
          return;
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    tv[n] = 1'b0;
    hv[n] = 1'b0;
  endtask

  // Monitor: round-robin model picks the expected owner; beats pop from that owner's queue.
  initial begin
    logic [79:0] eh;
    logic [9:0]  eb;
    bit c0, c1;
    int es;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        exp_hdr0.delete(); exp_hdr1.delete(); exp_beat0.delete(); exp_beat1.delete();
        last_m = 1;
      end else begin
        if (m_hdr_valid && m_hdr_ready) begin
          c0 = exp_hdr0.size() != 0;
          c1 = exp_hdr1.size() != 0;
          if (!c0 && !c1) begin
            checks++; errors++;
            $display("FAIL unexpected_hdr act=grant%0b exp=none", grant);
          end else begin
            es = (c0 && c1) ? ((last_m == 1) ? 0 : 1) : (c0 ? 0 : 1);
            chk("grant_at_hdr", grant, oh(es));
            eh = (es == 0) ? exp_hdr0.pop_front() : exp_hdr1.pop_front();
            chk("hdr_fields", {m_ip, m_sp, m_dp, m_len}, eh);
            cur = es;
          end
        end
        if (m_tvalid && m_tready) begin
          if ((cur == 0 && exp_beat0.size() == 0) || (cur == 1 && exp_beat1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL unexpected_beat act=%0h exp=none", {m_tuser, m_tlast, m_tdata});
          end else begin
            eb = (cur == 0) ? exp_beat0.pop_front() : exp_beat1.pop_front();
            chk("beat", {m_tuser, m_tlast, m_tdata}, eb);
            chk("owner_grant", grant, oh(cur));
            chk("other_tready", {hr[1-cur], tr[1-cur]}, 2'b00);
            if (eb[8]) last_m = cur;
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hv[0] = 1'b1; hv[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_idle("in_reset");
    @(negedge clk);
    hv[0] = 1'b0; hv[1] = 1'b0; tv[0] = 1'b0; tv[1] = 1'b0;
    rst_n = 1'b1;
    #4 chk_idle("after_reset");
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      hv[i] = 0; tv[i] = 0; tl[i] = 0; tu[i] = 0; td[i] = 0;
      dip[i] = 0; sp[i] = 0; dp[i] = 0; ln[i] = 0;
    end
    apply_reset();

    // Single source, 3 bytes, dest port 1234, header one cycle after request
    fork
      run_src(0, 1, 3, 16'd1234, 0, -1, -1, 0, 0);
      begin
        @(negedge clk); #4 chk("lat_before", m_hdr_valid, 1'b0);
        @(negedge clk); #4 chk("lat_hdr", {m_hdr_valid, grant}, 3'b101);
      end
    join
    #4 chk_idle("after_single");
    chk_drained("drained_single");

    // Simultaneous requests after reset: s0 first
    apply_reset();
    fork
      run_src(0, 1, 0, 16'd0, 0, -1, -1, 0, 0);
      run_src(1, 1, 0, 16'd0, 0, -1, -1, 0, 0);
    join
    chk_drained("drained_tie");

    // Continuous contention with random sink and source gaps
    mode = 2;
    fork
      run_src(0, 4, 0, 16'd0, 30, -1, -1, 0, 0);
      run_src(1, 4, 0, 16'd0, 30, -1, -1, 0, 0);
    join
    mode = 0;
    repeat (2) @(negedge clk);
    chk_drained("drained_contention");

    // Toggling payload ready over a 5-byte frame
    mode = 1;
    run_src(0, 1, 5, 16'd0, 0, -1, -1, 0, 0);
    mode = 0;
    repeat (2) @(negedge clk);
    chk_drained("drained_toggle");

    // Reset while the second payload beat is presented
    run_src(0, 1, 5, 16'd0, 0, 1, -1, 0, 0);
    @(posedge clk);
    #1 chk_idle("reset_mid_frame");
    @(negedge clk);
    tv[0] = 1'b0; hv[0] = 1'b0;
    rst_n = 1'b1;
    run_src(1, 1, 0, 16'd0, 0, -1, -1, 0, 0);
    #4 chk_idle("after_reset_frame");
    chk_drained("drained_after_reset");

`ifdef UDP_TX_ARB_WDOG_EN
    // s1 stalls after two beats; expect forced tlast/tuser beat after WDOG stalled cycles, then drain
    fork
      run_src(1, 1, 5, 16'd0, 0, -1, 2, 12, 1);
      begin
        int beats, stall, t;
        beats = 0; stall = 0; t = 0;
        while (beats < 2 && t < 200) begin
          @(negedge clk); #4;
          if (m_tvalid && m_tready) beats++;
          t++;
        end
        @(negedge clk); #4;
        while (!m_tvalid && t < 200) begin stall++; t++; @(negedge clk); #4; end
        chk("wdog_stall_cycles", stall, WDOG);
        chk("wdog_forced_beat", {wdog_abort, m_tvalid, m_tlast, m_tuser, m_tdata}, {4'hf, 8'h00});
        @(negedge clk); #4 chk("wdog_pulse_width", wdog_abort, 1'b0);
      end
    join
    #4 chk_idle("after_wdog");
    chk_drained("drained_wdog");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 Parameter WDOG_CYCLES, default 1024: payload stall limit in cycles; used only when UDP_TX_ARB_WDOG_EN is defined.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 sN_udp_hdr_valid / sN_udp_hdr_ready  in / out  1 / 1  header handshake of source N (N=0,1).
REQ-005 sN_udp_ip_dest_ip, sN_udp_source_port, sN_udp_dest_port, sN_udp_length  in  32,16,16,16  header fields of source N.
REQ-006 sN_udp_payload_axis_tdata/tvalid/tlast/tuser  in  8/1/1/1  payload stream of source N; sN_udp_payload_axis_tready  out  1.
REQ-007 m_udp_hdr_valid  out  1 and m_udp_hdr_ready  in  1: header handshake toward the UDP stack.
REQ-008 m_udp_ip_dest_ip, m_udp_source_port, m_udp_dest_port, m_udp_length  out  32,16,16,16  selected header fields.
REQ-009 m_udp_payload_axis_tdata/tvalid/tlast/tuser  out  8/1/1/1; m_udp_payload_axis_tready  in  1.
REQ-010 grant  out  2  one-hot owner (bit N = source N), 0 when idle.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 wdog_abort  out  1  one-cycle pulse when a frame is force-terminated.

Function
REQ-013 FSM states: IDLE, HDR, PAYLOAD, DRAIN (DRAIN only reachable with UDP_TX_ARB_WDOG_EN).
REQ-014 IDLE: if any sN_udp_hdr_valid, register grant round-robin (source not last served wins a tie), go to HDR next cycle; else stay.
REQ-015 Arbitration latency: m_udp_hdr_valid rises exactly one cycle after the winning sN_udp_hdr_valid is sampled in IDLE.
REQ-016 HDR: m_udp_hdr_valid = granted sN_udp_hdr_valid; header fields muxed combinationally from granted source; granted sN_udp_hdr_ready = m_udp_hdr_ready; non-granted hdr_ready = 0.
REQ-017 HDR -> PAYLOAD on m_udp_hdr_valid && m_udp_hdr_ready.
REQ-018 PAYLOAD: m payload signals = granted source's; granted tready = m_udp_payload_axis_tready; non-granted tready = 0.
REQ-019 PAYLOAD -> IDLE on tvalid && tready && tlast beat; last-served pointer updated to granted source in that cycle.
REQ-020 Grant never changes mid-frame; a requester asserting hdr_valid while another owns the stack waits, never loses its request.
REQ-021 Outside HDR, m_udp_hdr_valid = 0 and all sN_udp_hdr_ready = 0; outside PAYLOAD/DRAIN, m payload tvalid = 0 and all source tready = 0.
REQ-022 Back-to-back frames: after the tlast beat, IDLE arbitrates the following cycle; with both requesting continuously, grants alternate 0,1,0,1.
REQ-023 tuser passes through unmodified in PAYLOAD.

Reset
REQ-024 rst_n low at a clock edge: state = IDLE, grant = 0, last-served = source 1 (source 0 wins first tie), watchdog counter = 0.
REQ-025 During reset and the cycle after: all valid/ready outputs, busy, wdog_abort = 0; data outputs = 0.
REQ-026 Reset mid-frame aborts the frame without emitting tlast; the downstream is reset from the same rst_n.

Configuration
REQ-027 Macro UDP_TX_ARB_WDOG_EN defined: in PAYLOAD a counter increments each cycle without a payload handshake, clears on each handshake.
REQ-028 On reaching WDOG_CYCLES: source tready = 0; drive m tvalid=1, tlast=1, tuser=1, tdata=0 until accepted; pulse wdog_abort on acceptance; enter DRAIN.
REQ-029 DRAIN: granted source tready = 1, beats discarded, m tvalid = 0; exit to IDLE on source tlast beat, last-served updated.
REQ-030 Macro undefined: no counter, no DRAIN; wdog_abort tied 0; PAYLOAD waits indefinitely.

Verification
REQ-031 Only s0 requests, dest_port 1234, 3-byte payload, m ready=1 -> hdr out 1 cycle after request, 3 beats out, grant=01, then 00.
REQ-032 s0 and s1 request in same cycle after reset -> s0 served first, s1 second; s1 tready stays 0 during s0 frame.
REQ-033 Both request continuously, 4 frames each -> output grant order 0,1,0,1,... with no interleaved beats.
REQ-034 m_udp_payload_axis_tready toggled 1/0 each cycle during a 5-byte frame -> exactly 5 beats, order preserved, tlast on 5th only.
REQ-035 rst_n low during PAYLOAD beat 2 -> next cycle all outputs 0, state IDLE; new request after release served normally.
REQ-036 WDOG_EN, WDOG_CYCLES=8, s1 stalls after 2 beats -> 8 idle cycles then forced beat tlast=1,tuser=1,tdata=0, wdog_abort pulse; s1 remainder drained until tlast.
